trng_word_arbiter: RTL and testbench

Consumer-side controller for the `trng` core. It packs the serial `o_warbler` stream, qualified by `o_valid`, into `WORD_W`-bit words and buffers them in a small FIFO. It hands each word to exactly one of `NREQ` requesters under round-robin arbitration. A repetition-count health test runs on the stream and latches an alarm that blocks all further output until reset.

---
 rtl/trng_pkg.sv | 16 +
 rtl/trng_word_fifo.sv | 89 ++++++++
 rtl/trng_word_arbiter.sv | 179 +++++++++++++++++
 tb/tb_trng_word_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and default sizing for the trng word arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package trng_pkg;

    localparam int TRNG_WORD_W     = 8;
    localparam int TRNG_NREQ       = 4;
    localparam int TRNG_FIFO_DEPTH = 4;
    localparam int TRNG_REP_LIMIT  = 16;

    typedef enum logic [0:0] {
        ARB_RUN   = 1'b0,
        ARB_ALARM = 1'b1
    } trng_arb_state_e;

endpackage

// File: rtl/trng_word_fifo.sv
// Small synchronous word FIFO between the bit packer and the arbiter.
// Latency: a word pushed on edge N is visible on head after edge N (no bypass while empty).
// Backpressure: none; the caller decides drops; pop on empty and push on full without pop are ignored.
// Ports: clk/rst (sync, active-high); push/push_dat write; pop advances head;
//        flush empties in one edge and wins over push/pop; head, level, full report status.
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int WORD_W = TRNG_WORD_W,
    parameter int DEPTH  = TRNG_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_dat,
    input  logic              pop,
    input  logic              flush,
    output logic [WORD_W-1:0] head,
    output logic [LVL_W-1:0]  level,
    output logic              full
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  cnt_q, cnt_d;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + LVL_W'(1);
                2'b01:   cnt_d = cnt_q - LVL_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone says what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = cnt_q;

endmodule

// File: rtl/trng_word_arbiter.sv
// Packs the qualified trng bit stream into words, queues them and grants each to one requester round-robin.
// Latency: word push to earliest grant is one edge; req to o_gnt is one edge; o_gnt/o_data last one cycle.
// Backpressure: none upstream; words arriving at a full FIFO with no pop are dropped; a repetition alarm blocks all output.
// Ports: clk/rst (sync, active-high); i_valid/i_bit serial input; req level requests;
//        o_gnt one-hot grant with o_data; o_level FIFO occupancy; o_alarm sticky health failure.
module trng_word_arbiter
    import trng_pkg::*;
#(
    parameter int WORD_W    = TRNG_WORD_W,
    parameter int NREQ      = TRNG_NREQ,
    parameter int DEPTH     = TRNG_FIFO_DEPTH,
    parameter int REP_LIMIT = TRNG_REP_LIMIT,
    localparam int BCNT_W   = $clog2(WORD_W),
    localparam int LAST_W   = $clog2(NREQ),
    localparam int LVL_W    = $clog2(DEPTH + 1),
    localparam int REP_W    = $clog2(REP_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_bit,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   o_gnt,
    output logic [WORD_W-1:0] o_data,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_alarm
);

    trng_arb_state_e   state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              prev_q, prev_d;
    logic [LAST_W-1:0] last_q, last_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WORD_W-1:0] data_q, data_d;

    logic [WORD_W-1:0] word;
    logic              word_done;
    logic [REP_W-1:0]  rep_next;
    logic              health_fail;
    logic              rr_found;
    logic [LAST_W-1:0] rr_winner;
    logic [LAST_W-1:0] rr_cand;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [WORD_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;

    trng_word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (word),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .head     (fifo_head),
        .level    (fifo_level),
        .full     (fifo_full)
    );

    assign word = {shift_q[WORD_W-2:0], i_bit};

    // rep_q == 0 marks "no valid bit seen yet", so the first bit always starts a run of 1.
    always_comb begin
        rep_next = REP_W'(1);
        if (rep_q != '0 && i_bit == prev_q) begin
            rep_next = (rep_q == REP_W'(REP_LIMIT)) ? rep_q : rep_q + REP_W'(1);
        end
    end

    assign health_fail = i_valid && (rep_next == REP_W'(REP_LIMIT));

    // Round-robin: search upward from the slot after the last winner, wrapping.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_q;
        rr_cand   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_cand = LAST_W'((int'(last_q) + i) % NREQ);
            if (!rr_found && req[rr_cand]) begin
                rr_found  = 1'b1;
                rr_winner = rr_cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        rep_d      = rep_q;
        prev_d     = prev_q;
        last_d     = last_q;
        gnt_d      = '0;
        data_d     = '0;
        word_done  = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            ARB_RUN: begin
                if (health_fail) begin
                    // Failing bit, partial word and queued words are all discarded;
                    // no grant is made on this edge either.
                    state_d    = ARB_ALARM;
                    shift_d    = '0;
                    bcnt_d     = '0;
                    rep_d      = rep_next;
                    prev_d     = i_bit;
                    fifo_flush = 1'b1;
                end else begin
                    if (i_valid) begin
                        rep_d   = rep_next;
                        prev_d  = i_bit;
                        shift_d = word;
                        if (bcnt_q == BCNT_W'(WORD_W - 1)) begin
                            bcnt_d    = '0;
                            word_done = 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + BCNT_W'(1);
                        end
                    end
                    // Grant uses the head as it stood before this edge, so a
                    // word pushed now is only grantable from the next edge.
                    if (rr_found && fifo_level != '0) begin
                        gnt_d[rr_winner] = 1'b1;
                        data_d           = fifo_head;
                        fifo_pop         = 1'b1;
                        last_d           = rr_winner;
                    end
                    // Full without a simultaneous pop: the word is dropped.
                    fifo_push = word_done && (!fifo_full || fifo_pop);
                end
            end
            ARB_ALARM: begin
                state_d = ARB_ALARM;
            end
            default: begin
                state_d = ARB_ALARM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_RUN;
            shift_q <= '0;
            bcnt_q  <= '0;
            rep_q   <= '0;
            prev_q  <= 1'b0;
            last_q  <= LAST_W'(NREQ - 1);
            gnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            rep_q   <= rep_d;
            prev_q  <= prev_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_data  = data_q;
    assign o_level = fifo_level;
    assign o_alarm = (state_q == ARB_ALARM);

endmodule

// File: tb/tb_trng_word_arbiter.sv
// Directed bench for trng_word_arbiter with hand-computed expectations.
// Latency: inputs change 1ns after a rising edge; outputs are checked at the same point.
// Backpressure: n/a.
module tb_trng_word_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic       i_bit;
    logic [3:0] req;
    logic [3:0] o_gnt;
    logic [7:0] o_data;
    logic [2:0] o_level;
    logic       o_alarm;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trng_word_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_bit   (i_bit),
        .req     (req),
        .o_gnt   (o_gnt),
        .o_data  (o_data),
        .o_level (o_level),
        .o_alarm (o_alarm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_bit   = 1'b0;
        req     = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Sends the top nbits of w, MSB first, one valid bit per cycle.
    task automatic send_word(input logic [7:0] w, input int nbits);
        for (int i = 7; i >= 8 - nbits; i--) begin
            i_valid = 1'b1;
            i_bit   = w[i];
            tick();
        end
        i_valid = 1'b0;
    endtask

    // One valid bit every 5th cycle.
    task automatic sparse_bit(input logic b);
        i_valid = 1'b0;
        repeat (4) tick();
        i_valid = 1'b1;
        i_bit   = b;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] w;

        // Reset state
        do_reset();
        check("rst_gnt", o_gnt, 4'b0000);
        check("rst_data", o_data, 8'h00);
        check("rst_level", o_level, 3'd0);
        check("rst_alarm", o_alarm, 1'b0);

        // Basic word
        req = 4'b0001;
        send_word(8'hAA, 7);
        check("basic_lvl7", o_level, 3'd0);
        i_valid = 1'b1;
        i_bit   = 1'b0;
        tick();
        i_valid = 1'b0;
        check("basic_lvl8", o_level, 3'd1);
        check("basic_nobypass", o_gnt, 4'b0000);
        tick();
        check("basic_gnt", o_gnt, 4'b0001);
        check("basic_data", o_data, 8'hAA);
        check("basic_lvl_pop", o_level, 3'd0);
        req = 4'b0000;
        tick();
        check("basic_gnt_off", o_gnt, 4'b0000);
        check("basic_data_off", o_data, 8'h00);

        // Round robin
        do_reset();
        send_word(8'h11, 8);
        send_word(8'h22, 8);
        send_word(8'h33, 8);
        send_word(8'h44, 8);
        check("rr_preload", o_level, 3'd4);
        req = 4'b1111;
        tick();
        check("rr_gnt0", o_gnt, 4'b0001);
        check("rr_data0", o_data, 8'h11);
        check("rr_lvl0", o_level, 3'd3);
        tick();
        check("rr_gnt1", o_gnt, 4'b0010);
        check("rr_data1", o_data, 8'h22);
        tick();
        check("rr_gnt2", o_gnt, 4'b0100);
        check("rr_data2", o_data, 8'h33);
        tick();
        check("rr_gnt3", o_gnt, 4'b1000);
        check("rr_data3", o_data, 8'h44);
        check("rr_lvl3", o_level, 3'd0);
        tick();
        check("rr_empty_gnt", o_gnt, 4'b0000);
        check("rr_empty_data", o_data, 8'h00);

        // Full FIFO drop, then push+pop on a full FIFO
        do_reset();
        send_word(8'hA1, 8);
        send_word(8'hB2, 8);
        send_word(8'hC3, 8);
        send_word(8'hD4, 8);
        check("full_lvl4", o_level, 3'd4);
        send_word(8'hE5, 8);
        check("full_drop_lvl", o_level, 3'd4);
        send_word(8'h5A, 7);
        req     = 4'b0100;
        i_valid = 1'b1;
        i_bit   = 1'b0;
        tick();
        i_valid = 1'b0;
        check("full_pp_gnt", o_gnt, 4'b0100);
        check("full_pp_data", o_data, 8'hA1);
        check("full_pp_lvl", o_level, 3'd4);
        tick();
        check("full_data_b2", o_data, 8'hB2);
        check("full_gnt_b2", o_gnt, 4'b0100);
        tick();
        check("full_data_c3", o_data, 8'hC3);
        tick();
        check("full_data_d4", o_data, 8'hD4);
        tick();
        check("full_data_5a", o_data, 8'h5A);
        check("full_gnt_5a", o_gnt, 4'b0100);
        check("full_lvl_end", o_level, 3'd0);
        tick();
        check("full_no_e5", o_gnt, 4'b0000);

        // Health failure
        do_reset();
        send_word(8'hAA, 8);
        send_word(8'hAA, 8);
        send_word(8'hAA, 8);
        check("hlth_lvl3", o_level, 3'd3);
        w = 8'hFF;
        send_word(w, 8);
        send_word(w, 7);
        check("hlth_15_alarm", o_alarm, 1'b0);
        check("hlth_15_lvl", o_level, 3'd4);
        req     = 4'b1111;
        i_valid = 1'b1;
        i_bit   = 1'b1;
        tick();
        i_valid = 1'b0;
        check("hlth_alarm", o_alarm, 1'b1);
        check("hlth_flush", o_level, 3'd0);
        check("hlth_gnt_edge", o_gnt, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            i_valid = 1'b1;
            i_bit   = c[0];
            tick();
            check("hlth_blocked", o_gnt, 4'b0000);
        end
        i_valid = 1'b0;
        check("hlth_lvl_held", o_level, 3'd0);
        check("hlth_sticky", o_alarm, 1'b1);
        do_reset();
        check("hlth_rst_clear", o_alarm, 1'b0);

        // Sparse stream with reset mid-word
        sparse_bit(1'b1);
        sparse_bit(1'b1);
        sparse_bit(1'b0);
        sparse_bit(1'b1);
        sparse_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sparse_rst_gnt", o_gnt, 4'b0000);
        req = 4'b0001;
        w   = 8'hC3;
        for (int i = 7; i >= 1; i--) begin
            sparse_bit(w[i]);
        end
        check("sparse_lvl7", o_level, 3'd0);
        sparse_bit(w[0]);
        check("sparse_lvl8", o_level, 3'd1);
        tick();
        check("sparse_gnt", o_gnt, 4'b0001);
        check("sparse_data", o_data, 8'hC3);
        req = 4'b0000;
        tick();
        check("sparse_gnt_off", o_gnt, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
